nn_load_sequencer: RTL

//  Top-level run controller for the SDRAM loader (sdram_interface) and the NN compute engine. On one

---
 rtl/nn_load_sequencer_if.sv | 46 ++++
 rtl/nn_load_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/nn_load_sequencer_if.sv
// nn_load_sequencer_if: run-control bundle between the sequencer,
// the SDRAM loader and the NN compute engine.
// Ports (master = sequencer side):
//   start, ld_busy, layer_done              -> into sequencer
//   get_data, which_data, layer_start,
//   layer_idx, run_busy, done, error        <- out of sequencer
interface nn_load_sequencer_if #(
  parameter int NUMLAYERS = 2
);
  logic                 start;
  logic                 ld_busy;
  logic                 layer_done;
  logic                 get_data;
  logic [NUMLAYERS-1:0] which_data;
  logic                 layer_start;
  logic [NUMLAYERS-1:0] layer_idx;
  logic                 run_busy;
  logic                 done;
  logic                 error;

  modport master (
    input  start,
    input  ld_busy,
    input  layer_done,
    output get_data,
    output which_data,
    output layer_start,
    output layer_idx,
    output run_busy,
    output done,
    output error
  );

  modport slave (
    output start,
    output ld_busy,
    output layer_done,
    input  get_data,
    input  which_data,
    input  layer_start,
    input  layer_idx,
    input  run_busy,
    input  done,
    input  error
  );
endinterface

// File: rtl/nn_load_sequencer.sv
// nn_load_sequencer: loads the image, then per layer loads coefficients
// and runs the compute engine; per-wait watchdog with sticky error.
// Ports: clk, reset_n (async, active low), bus (nn_load_sequencer_if.master).
module nn_load_sequencer #(
  parameter int                 NUMLAYERS = 2,
  parameter int                 LAYERS    = 3,
  parameter int                 TOWIDTH   = 24,
  parameter logic [TOWIDTH-1:0] TIMEOUT   = 24'hFFFFFF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nn_load_sequencer_if.master    bus
);

  typedef enum logic [3:0] {
    IDLE,
    IMG_REQ,
    IMG_WAIT,
    COEF_REQ,
    COEF_WAIT,
    COMP_START,
    COMP_WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [NUMLAYERS-1:0] IMG_CODE = '1;
  localparam logic [NUMLAYERS-1:0] LAST     = NUMLAYERS'(LAYERS - 1);
  localparam logic [TOWIDTH-1:0]   WD_MAX   = '1;
  localparam logic [TOWIDTH-1:0]   TO_LAST  = TIMEOUT - TOWIDTH'(1);

  state_t               state, state_d;
  logic [NUMLAYERS-1:0] idx_q, idx_d;
  logic                 err_q, err_d;
  logic [TOWIDTH-1:0]   wd_q;
  logic                 counting;
  logic                 expired;
  logic [NUMLAYERS-1:0] sel;

  assign counting = (state == IMG_REQ)   || (state == IMG_WAIT)  ||
                    (state == COEF_REQ)  || (state == COEF_WAIT) ||
                    (state == COMP_WAIT);

  // The counter starts at 0 on state entry, so the cycle that would
  // make it reach TIMEOUT is the last one allowed in this state.
  assign expired = counting && (TIMEOUT != '0) && (wd_q >= TO_LAST);

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    err_d   = err_q;
    if (expired) begin
      state_d = ERR;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_d = IMG_REQ;
            idx_d   = '0;
            err_d   = 1'b0;
          end
        end
        IMG_REQ:   if (bus.ld_busy)  state_d = IMG_WAIT;
        IMG_WAIT:  if (!bus.ld_busy) state_d = COEF_REQ;
        COEF_REQ:  if (bus.ld_busy)  state_d = COEF_WAIT;
        COEF_WAIT: if (!bus.ld_busy) state_d = COMP_START;
        COMP_START: state_d = COMP_WAIT;
        COMP_WAIT: begin
          if (bus.layer_done) begin
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              state_d = COEF_REQ;
              idx_d   = idx_q + NUMLAYERS'(1);
            end
          end
        end
        DONE: state_d = IDLE;
        ERR: begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx_q <= '0;
      err_q <= 1'b0;
      wd_q  <= '0;
    end else begin
      state <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      if ((state_d != state) || !counting) begin
        wd_q <= '0;
      end else if (wd_q != WD_MAX) begin
        wd_q <= wd_q + TOWIDTH'(1);
      end
    end
  end

  always_comb begin
    sel = '0;
    unique case (1'b1)
      (state == IMG_REQ)  || (state == IMG_WAIT):  sel = IMG_CODE;
      (state == COEF_REQ) || (state == COEF_WAIT): sel = idx_q;
      default: sel = '0;
    endcase
  end

  assign bus.get_data    = (state == IMG_REQ) || (state == COEF_REQ);
  assign bus.which_data  = sel;
  assign bus.layer_start = (state == COMP_START);
  assign bus.layer_idx   = idx_q;
  assign bus.run_busy    = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.error       = err_q;

endmodule
